// File: rtl/pipelined_barrel_shifter.sv
// Pipelined LSL/LSR/ASR/ROR barrel shifter with ARM-style carry-out.
// Log-shifter sub-stages are spread over PIPE register stages behind one global advance enable.
module pipelined_barrel_shifter #(
    parameter  int WIDTH   = 32,
    parameter  int PIPE    = 2,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [1:0]         in_op,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic               in_carry,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_carry
);

    localparam int SUB  = (SHAMT_W + PIPE - 1) / PIPE;
    localparam int NMID = (PIPE > 1) ? PIPE - 1 : 1;

    function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0] d,
                                                 input logic [1:0]       op,
                                                 input int               amt);
        logic [WIDTH-1:0] r;
        case (op)
            2'b00:   r = d << amt;
            2'b01:   r = d >> amt;
            2'b10:   r = $unsigned($signed(d) >>> amt);
            default: r = (d >> amt) | (d << (WIDTH - amt));
        endcase
        return r;
    endfunction

    // Sub-stage j (shift by 2**j) belongs to register stage j / SUB.
    function automatic logic [WIDTH-1:0] stage_shift(input logic [WIDTH-1:0]   d,
                                                    input logic [1:0]         op,
                                                    input logic [SHAMT_W-1:0] sh,
                                                    input int                 stg);
        logic [WIDTH-1:0] r;
        r = d;
        for (int j = 0; j < SHAMT_W; j++) begin
            if ((j / SUB) == stg && sh[j]) begin
                r = shift_by(r, op, 1 << j);
            end
        end
        return r;
    endfunction

    logic                 adv;
    logic [PIPE-1:0]      valid_q, valid_src;
    logic [PIPE-1:0]      carry_q, carry_src;
    logic [WIDTH-1:0]     data_q   [PIPE];
    logic [WIDTH-1:0]     data_src [PIPE];
    logic [WIDTH-1:0]     data_d   [PIPE];
    logic [1:0]           op_q     [NMID];
    logic [1:0]           op_src   [PIPE];
    logic [SHAMT_W-1:0]   shamt_q  [NMID];
    logic [SHAMT_W-1:0]   shamt_src[PIPE];
    logic [SHAMT_W-1:0]   lsl_idx, rsh_idx;
    logic                 carry_in;

    assign adv       = ~valid_q[PIPE-1] | out_ready;
    assign in_ready  = adv;
    assign out_valid = valid_q[PIPE-1];
    assign out_data  = data_q[PIPE-1];
    assign out_carry = carry_q[PIPE-1];

    // Carry is taken from the untouched operand; -n wraps to WIDTH-n.
    always_comb begin
        lsl_idx = -in_shamt;
        rsh_idx = in_shamt - SHAMT_W'(1);
        if (in_shamt == '0) begin
            carry_in = in_carry;
        end else if (in_op == 2'b00) begin
            carry_in = in_data[lsl_idx];
        end else begin
            carry_in = in_data[rsh_idx];
        end
    end

    always_comb begin
        valid_src    = '0;
        carry_src    = '0;
        valid_src[0] = in_valid;
        carry_src[0] = carry_in;
        data_src[0]  = in_data;
        op_src[0]    = in_op;
        shamt_src[0] = in_shamt;
        for (int k = 1; k < PIPE; k++) begin
            valid_src[k] = valid_q[k-1];
            carry_src[k] = carry_q[k-1];
            data_src[k]  = data_q[k-1];
            op_src[k]    = op_q[k-1];
            shamt_src[k] = shamt_q[k-1];
        end
        for (int k = 0; k < PIPE; k++) begin
            data_d[k] = stage_shift(data_src[k], op_src[k], shamt_src[k], k);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            carry_q <= '0;
            for (int k = 0; k < PIPE; k++) begin
                data_q[k] <= '0;
            end
            for (int k = 0; k < NMID; k++) begin
                op_q[k]    <= '0;
                shamt_q[k] <= '0;
            end
        end else if (adv) begin
            valid_q <= valid_src;
            carry_q <= carry_src;
            for (int k = 0; k < PIPE; k++) begin
                data_q[k] <= data_d[k];
            end
            for (int k = 0; k < PIPE - 1; k++) begin
                op_q[k]    <= op_src[k];
                shamt_q[k] <= shamt_src[k];
            end
        end
    end

endmodule
